// File: rtl/consensus_scheduler.sv
// UNL divergence vote reduction: scans the cell array LANES votes per cycle, stalls the
// sequencer while scanning. Optional macro CONSENSUS_EARLY_EXIT_EN stops at the first deciding vote.
module consensus_scheduler #(
    parameter int   NUM_CELLS = 64,
    parameter int   LANES     = 8,
    localparam int  GROUPS    = NUM_CELLS / LANES,
    localparam int  GW        = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_i,
    output logic [GW-1:0]    group_sel_o,
    input  logic [LANES-1:0] votes_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             diverge_consensus_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grp_q, grp_d;
    logic            mode_q, mode_d;
    logic            acc_q, acc_d;
    logic            cons_q, cons_d;
    logic            acc_next_s;
    logic            last_grp_s;
    logic            early_exit_s;

    // Accumulator update for the group on the vote port this cycle
    always_comb begin
        acc_next_s = mode_q ? (acc_q | (|votes_i)) : (acc_q & (&votes_i));
        last_grp_s = (grp_q == GW'(GROUPS - 1));
    end

`ifdef CONSENSUS_EARLY_EXIT_EN
    // A single 0 decides ALL, a single 1 decides ANY; the rest of the array cannot change it
    always_comb begin
        early_exit_s = mode_q ? (|votes_i) : ~(&votes_i);
    end
`else
    // Fixed-latency build: every group is always scanned
    always_comb begin
        early_exit_s = 1'b0;
    end
`endif

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grp_q   <= {GW{1'b0}};
            mode_q  <= 1'b0;
            acc_q   <= 1'b0;
            cons_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cons_q  <= cons_d;
        end
    end

    // Next-state logic; the result is captured on entry to DONE so it is visible with done
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cons_d  = cons_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                grp_d = {GW{1'b0}};
                if (start_i) begin
                    state_d = S_SCAN;
                    mode_d  = mode_i;
                    acc_d   = ~mode_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                acc_d = acc_next_s;
                if (last_grp_s || early_exit_s) begin
                    state_d = S_DONE;
                    grp_d   = {GW{1'b0}};
                    cons_d  = acc_next_s;
                end else begin
                    grp_d   = grp_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grp_d   = {GW{1'b0}};
            end
        endcase
    end

    // Stall is combinational so the sequencer holds PC in the very cycle UNL is decoded
    always_comb begin
        stall_o             = (state_q == S_SCAN) | (start_i & (state_q != S_SCAN));
        done_o              = (state_q == S_DONE);
        group_sel_o         = grp_q;
        diverge_consensus_o = cons_q;
    end

endmodule

// File: tb/tb_consensus_scheduler.sv
// Self-checking bench for consensus_scheduler: a scoreboard of expected scans (start cycle,
// done cycle, result) is filled when start is driven and checked every cycle.
module tb_consensus_scheduler;

    localparam int NUM_CELLS = 64;
    localparam int LANES     = 8;
    localparam int GROUPS    = NUM_CELLS / LANES;
    localparam int GW        = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic             mode_i;
    logic [GW-1:0]    group_sel_o;
    logic [LANES-1:0] votes_i;
    logic             stall_o;
    logic             done_o;
    logic             diverge_consensus_o;

    logic [NUM_CELLS-1:0] cells;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic exp_cons;

    typedef struct {
        int   s;
        int   d;
        logic cons;
    } exp_t;
    exp_t sb[$];

    consensus_scheduler #(.NUM_CELLS(NUM_CELLS), .LANES(LANES)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_i             (start_i),
        .mode_i              (mode_i),
        .group_sel_o         (group_sel_o),
        .votes_i             (votes_i),
        .stall_o             (stall_o),
        .done_o              (done_o),
        .diverge_consensus_o (diverge_consensus_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb votes_i = cells[int'(group_sel_o) * LANES +: LANES];

    function automatic int done_lat(input logic m);
        int lat;
        logic [LANES-1:0] v;
        lat = GROUPS + 1;
`ifdef CONSENSUS_EARLY_EXIT_EN
        for (int g = GROUPS - 1; g >= 0; g--) begin
            v = cells[g * LANES +: LANES];
            if (m ? (|v) : ~(&v)) lat = g + 2;
        end
`endif
        return lat;
    endfunction

    // one cycle: drive inputs, record accepted starts, compare outputs against the scoreboard
    task automatic step(input logic st, input logic m);
        exp_t e;
        logic st_e;
        logic dn_e;
        int   gs_e;
        @(negedge clk);
        start_i = st;
        mode_i  = m;
        if (st && (sb.size() == 0 || cyc >= sb[sb.size() - 1].d)) begin
            e.s    = cyc;
            e.d    = cyc + done_lat(m);
            e.cons = m ? (|cells) : (&cells);
            sb.push_back(e);
        end
        #1;
        st_e = 1'b0;
        dn_e = 1'b0;
        gs_e = 0;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].s <= cyc && cyc < sb[i].d) st_e = 1'b1;
            if (sb[i].s < cyc && cyc < sb[i].d) gs_e = cyc - sb[i].s - 1;
        end
        if (sb.size() > 0 && sb[0].d == cyc) begin
            dn_e     = 1'b1;
            exp_cons = sb[0].cons;
            void'(sb.pop_front());
        end
        tests++;
        if (stall_o !== st_e) begin
            fails++;
            $display("FAIL stall cyc=%0d got %b expected %b", cyc, stall_o, st_e);
        end
        tests++;
        if (group_sel_o !== GW'(gs_e)) begin
            fails++;
            $display("FAIL group_sel cyc=%0d got %0d expected %0d", cyc, group_sel_o, gs_e);
        end
        tests++;
        if (done_o !== dn_e) begin
            fails++;
            $display("FAIL done cyc=%0d got %b expected %b", cyc, done_o, dn_e);
        end
        tests++;
        if (diverge_consensus_o !== exp_cons) begin
            fails++;
            $display("FAIL consensus cyc=%0d got %b expected %b", cyc, diverge_consensus_o, exp_cons);
        end
    endtask

    task automatic run_scan(input string name, input logic m);
        step(1'b1, m);
        for (int i = 0; i < GROUPS + 3; i++) step(1'b0, ~m);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s timeout: %0d scans pending, required 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        mode_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if ({stall_o, done_o, group_sel_o, diverge_consensus_o} !== {1'b0, 1'b0, {GW{1'b0}}, 1'b0}) begin
                fails++;
                $display("FAIL reset_state stall=%b done=%b grp=%0d cons=%b required all 0",
                         stall_o, done_o, group_sel_o, diverge_consensus_o);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cons = 1'b0;
    endtask

    task automatic test_all_mode();
        cells = {NUM_CELLS{1'b1}};
        run_scan("all_ones", 1'b0);
        cells[37] = 1'b0;
        run_scan("all_cell37", 1'b0);
    endtask

    task automatic test_any_mode();
        cells = {NUM_CELLS{1'b0}};
        run_scan("any_zero", 1'b1);
        cells[60] = 1'b1;
        run_scan("any_cell60", 1'b1);
    endtask

    task automatic test_start_during_scan();
        cells = {NUM_CELLS{1'b1}};
        cells[62] = 1'b0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < GROUPS + 2; i++) step(1'b0, 1'b1);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL start_in_scan timeout: %0d scans pending, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_scan();
        cells = {NUM_CELLS{1'b1}};
        run_scan("pre_reset", 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        start_i = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({stall_o, done_o, group_sel_o, diverge_consensus_o} !== {1'b0, 1'b0, {GW{1'b0}}, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset stall=%b done=%b grp=%0d cons=%b required all 0",
                     stall_o, done_o, group_sel_o, diverge_consensus_o);
        end
        exp_cons = 1'b0;
        for (int i = 0; i < GROUPS + 2; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        cells = {NUM_CELLS{1'b0}};
        cells[60] = 1'b1;
        for (int i = 0; i < GROUPS + 1; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < GROUPS + 3; i++) step(1'b0, 1'b1);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL back_to_back timeout: %0d scans pending, required 0", sb.size());
        end
        sb.delete();
    endtask

    initial begin
        cells = {NUM_CELLS{1'b0}};
        exp_cons = 1'b0;
        test_reset();
        test_all_mode();
        test_any_mode();
        test_start_during_scan();
        test_reset_mid_scan();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
